// File: rtl/bull_cow_game_ctrl.sv
// rtl/bull_cow_game_ctrl.sv - bull/cow game sequencer: digit capture, scoring handshake, win/lose.
// Optional build macro: REJECT_REPEAT_EN (reject a second digit equal to the first).
module bull_cow_game_ctrl #(
    parameter int MAX_TRIES = 8,
    parameter int TRY_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       digit_in,
    input  logic             enter,
    input  logic [1:0]       score_bull,
    input  logic [1:0]       score_cow,
    output logic [3:0]       secret1,
    output logic [3:0]       secret0,
    output logic [3:0]       guess1,
    output logic [3:0]       guess0,
    output logic             score_valid,
    output logic [1:0]       last_bull,
    output logic [1:0]       last_cow,
    output logic [TRY_W-1:0] attempts,
    output logic             win,
    output logic             lose,
    output logic             digit_err,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_SET1   = 3'd0,
        S_SET0   = 3'd1,
        S_GUESS1 = 3'd2,
        S_GUESS0 = 3'd3,
        S_SCORE  = 3'd4,
        S_WIN    = 3'd5,
        S_LOSE   = 3'd6
    } state_t;

    localparam logic [TRY_W-1:0] MAX_CNT = TRY_W'(MAX_TRIES);

    state_t           state_q, state_d;
    logic [3:0]       secret1_q, secret1_d, secret0_q, secret0_d;
    logic [3:0]       guess1_q, guess1_d, guess0_q, guess0_d;
    logic             score_valid_q, score_valid_d;
    logic [1:0]       last_bull_q, last_bull_d, last_cow_q, last_cow_d;
    logic [TRY_W-1:0] attempts_q, attempts_d, attempts_inc;
    logic             win_q, win_d, lose_q, lose_d, digit_err_q, digit_err_d;
    logic             digit_bad;

    always_comb begin
        state_d       = state_q;
        secret1_d     = secret1_q;
        secret0_d     = secret0_q;
        guess1_d      = guess1_q;
        guess0_d      = guess0_q;
        score_valid_d = 1'b0;
        last_bull_d   = last_bull_q;
        last_cow_d    = last_cow_q;
        attempts_d    = attempts_q;
        win_d         = win_q;
        lose_d        = lose_q;
        digit_err_d   = 1'b0;

`ifdef REJECT_REPEAT_EN
        digit_bad = (digit_in > 4'd9)
                  || (state_q == S_SET0   && digit_in == secret1_q)
                  || (state_q == S_GUESS0 && digit_in == guess1_q);
`else
        digit_bad = (digit_in > 4'd9);
`endif

        // Saturate so the counter can never wrap past the loss threshold.
        attempts_inc = (attempts_q == MAX_CNT) ? attempts_q : attempts_q + TRY_W'(1);

        case (state_q)
            S_SET1, S_SET0, S_GUESS1, S_GUESS0: begin
                if (enter) begin
                    if (digit_bad) begin
                        digit_err_d = 1'b1;
                    end else begin
                        case (state_q)
                            S_SET1:   begin secret1_d = digit_in; state_d = S_SET0;   end
                            S_SET0:   begin secret0_d = digit_in; state_d = S_GUESS1; end
                            S_GUESS1: begin guess1_d  = digit_in; state_d = S_GUESS0; end
                            default:  begin guess0_d  = digit_in; state_d = S_SCORE;  end
                        endcase
                    end
                end
            end
            S_SCORE: begin
                last_bull_d   = score_bull;
                last_cow_d    = score_cow;
                score_valid_d = 1'b1;
                attempts_d    = attempts_inc;
                if (score_bull == 2'b11) begin
                    state_d = S_WIN;
                    win_d   = 1'b1;
                end else if (attempts_inc == MAX_CNT) begin
                    state_d = S_LOSE;
                    lose_d  = 1'b1;
                end else begin
                    state_d = S_GUESS1;
                end
            end
            S_WIN, S_LOSE: begin
                if (enter) begin
                    state_d     = S_SET1;
                    secret1_d   = '0;
                    secret0_d   = '0;
                    guess1_d    = '0;
                    guess0_d    = '0;
                    last_bull_d = '0;
                    last_cow_d  = '0;
                    attempts_d  = '0;
                    win_d       = 1'b0;
                    lose_d      = 1'b0;
                end
            end
            default: state_d = S_SET1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_SET1;
            secret1_q     <= '0;
            secret0_q     <= '0;
            guess1_q      <= '0;
            guess0_q      <= '0;
            score_valid_q <= 1'b0;
            last_bull_q   <= '0;
            last_cow_q    <= '0;
            attempts_q    <= '0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
            digit_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            secret1_q     <= secret1_d;
            secret0_q     <= secret0_d;
            guess1_q      <= guess1_d;
            guess0_q      <= guess0_d;
            score_valid_q <= score_valid_d;
            last_bull_q   <= last_bull_d;
            last_cow_q    <= last_cow_d;
            attempts_q    <= attempts_d;
            win_q         <= win_d;
            lose_q        <= lose_d;
            digit_err_q   <= digit_err_d;
        end
    end

    assign secret1     = secret1_q;
    assign secret0     = secret0_q;
    assign guess1      = guess1_q;
    assign guess0      = guess0_q;
    assign score_valid = score_valid_q;
    assign last_bull   = last_bull_q;
    assign last_cow    = last_cow_q;
    assign attempts    = attempts_q;
    assign win         = win_q;
    assign lose        = lose_q;
    assign digit_err   = digit_err_q;
    assign state       = state_q;

endmodule
